// File: rtl/i_cache_burst.sv
// 2-way set-associative instruction cache; a miss refills a whole line with one INCR burst.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counters.
module i_cache_burst #(
  parameter int unsigned INDEX_WIDTH = 7,
  parameter int unsigned LINE_WORDS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] pc_next,
  input  logic [31:0] pcF,
  input  logic        stallF,
  output logic [31:0] inst_rdata,
  output logic        stall,
  output logic        hit,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int unsigned SETS       = 1 << INDEX_WIDTH;
  localparam int unsigned WOFF_WIDTH = $clog2(LINE_WORDS);
  localparam int unsigned IDX_LSB    = WOFF_WIDTH + 2;
  localparam int unsigned TAG_LSB    = IDX_LSB + INDEX_WIDTH;
  localparam int unsigned TAG_WIDTH  = 32 - TAG_LSB;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, MISS_R, FILL, RESUME} state_e;

  state_e                 state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q      [2][SETS];
  logic [31:0]            data_q     [2][SETS][LINE_WORDS];
  logic [31:0]            line_buf_q [LINE_WORDS];
  logic [SETS-1:0]        valid_q [2];
  logic [SETS-1:0]        valid_d [2];
  logic [SETS-1:0]        lru_q, lru_d;
  logic [WOFF_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [INDEX_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [31:0]            araddr_q, araddr_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;

  logic [TAG_WIDTH-1:0]   tag_f;
  logic [INDEX_WIDTH-1:0] index_f, index_next;
  logic [WOFF_WIDTH-1:0]  word_f;
  logic [1:0]             way_hit;
  logic                   hit_way, victim, lookup_hit, fill_we, buf_we;
  logic                   unused_bits;

  assign tag_f       = pcF[31:TAG_LSB];
  assign index_f     = pcF[TAG_LSB-1:IDX_LSB];
  assign index_next  = pc_next[TAG_LSB-1:IDX_LSB];
  assign word_f      = pcF[IDX_LSB-1:2];
  assign unused_bits = ^{pc_next[31:TAG_LSB], pc_next[IDX_LSB-1:0], pcF[1:0]};

  // Lookup against the array row latched at the previous edge
  assign way_hit[0] = valid_q[0][rd_idx_q] && (tag_q[0][rd_idx_q] == tag_f);
  assign way_hit[1] = valid_q[1][rd_idx_q] && (tag_q[1][rd_idx_q] == tag_f);
  assign hit_way    = way_hit[1];
  assign lookup_hit = (state_q == LOOKUP) && (|way_hit);
  assign hit        = lookup_hit;
  assign stall      = inst_en && !lookup_hit;
  assign inst_rdata = data_q[hit_way][rd_idx_q][word_f];
  assign victim     = !valid_q[0][index_f] ? 1'b0 :
                      (!valid_q[1][index_f] ? 1'b1 : lru_q[index_f]);

  assign araddr  = araddr_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign arlen   = 8'(LINE_WORDS - 1);

  // Next state, handshake flags and refill bookkeeping
  always_comb begin
    state_d    = state_q;
    arvalid_d  = 1'b0;
    rready_d   = 1'b0;
    araddr_d   = araddr_q;
    beat_cnt_d = beat_cnt_q;
    fill_we    = 1'b0;
    buf_we     = 1'b0;
    case (state_q)
      IDLE:   state_d = LOOKUP;
      LOOKUP: begin
        if (inst_en && !lookup_hit) begin
          state_d   = MISS_AR;
          arvalid_d = 1'b1;
          araddr_d  = {pcF[31:IDX_LSB], {IDX_LSB{1'b0}}};
        end
      end
      MISS_AR: begin
        if (arready) begin
          state_d    = MISS_R;
          rready_d   = 1'b1;
          beat_cnt_d = '0;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      MISS_R: begin
        if (rvalid) begin
          buf_we     = 1'b1;
          beat_cnt_d = beat_cnt_q + WOFF_WIDTH'(1);
        end
        if (rvalid && rlast) state_d = FILL;
        else                 rready_d = 1'b1;
      end
      FILL: begin
        fill_we = 1'b1;
        state_d = RESUME;
      end
      RESUME:  state_d = LOOKUP;
      default: state_d = IDLE;
    endcase
  end

  // Advance the read row with the pipeline only when the current fetch completes
  always_comb begin
    rd_idx_d = ((state_q == LOOKUP) && !stall && !stallF) ? index_next : index_f;
    lru_d    = lru_q;
    valid_d  = valid_q;
    if (lookup_hit && inst_en) lru_d[index_f] = ~hit_way;
    if (fill_we) begin
      lru_d[index_f]           = ~victim;
      valid_d[victim][index_f] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
      beat_cnt_q <= '0;
      rd_idx_q   <= '0;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      lru_q      <= lru_d;
      beat_cnt_q <= beat_cnt_d;
      rd_idx_q   <= rd_idx_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
    end
  end

  // Storage arrays carry no reset; valid bits gate their contents
  always_ff @(posedge clk) begin
    if (buf_we) line_buf_q[beat_cnt_q] <= rdata;
    if (fill_we) begin
      tag_q[victim][index_f]  <= tag_f;
      data_q[victim][index_f] <= line_buf_q;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Saturating event counters
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup_hit && inst_en && !stallF && (hit_cnt_q != '1))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if ((state_q == LOOKUP) && (state_d == MISS_AR) && (miss_cnt_q != '1))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule
